// File: rtl/unary_stream_encoder.sv
// Unary stream encoder: converts binary operand triples into three lock-stepped
// thermometer-coded bitstreams, one fixed frame of 2^BIN_BITS cycles per triple.
module unary_stream_encoder #(
    parameter int BIN_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_BITS-1:0] a_bin,
    input  logic [BIN_BITS-1:0] b_bin,
    input  logic [BIN_BITS-1:0] c_bin,
    input  logic                out_en,
    output logic                a,
    output logic                b,
    output logic                c,
    output logic                frame_start,
    output logic                busy
);

    localparam logic [BIN_BITS-1:0] CNT_LAST = '1;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t              state_q;
    logic [BIN_BITS-1:0] cnt_q;
    logic [BIN_BITS-1:0] cnt_d;
    logic [BIN_BITS-1:0] act_a_q, act_b_q, act_c_q;
    logic [BIN_BITS-1:0] pend_a_q, pend_b_q, pend_c_q;
    logic                pend_valid_q;
    logic                accept;
    logic                frame_last;
    logic                transfer;

    assign in_ready   = !reset && !pend_valid_q;
    assign accept     = in_valid && in_ready;
    assign cnt_d      = cnt_q + BIN_BITS'(1);
    assign frame_last = (state_q == STREAM) && out_en && (cnt_q == CNT_LAST);
    // accept needs an empty pending slot and transfer needs a full one, so the
    // two can never touch the pending registers on the same edge.
    assign transfer   = pend_valid_q && ((state_q == IDLE) || frame_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            act_a_q      <= '0;
            act_b_q      <= '0;
            act_c_q      <= '0;
            pend_a_q     <= '0;
            pend_b_q     <= '0;
            pend_c_q     <= '0;
            pend_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                pend_a_q     <= a_bin;
                pend_b_q     <= b_bin;
                pend_c_q     <= c_bin;
                pend_valid_q <= 1'b1;
            end

            if (transfer) begin
                act_a_q      <= pend_a_q;
                act_b_q      <= pend_b_q;
                act_c_q      <= pend_c_q;
                cnt_q        <= '0;
                state_q      <= STREAM;
                pend_valid_q <= 1'b0;
            end else if (frame_last) begin
                cnt_q   <= '0;
                state_q <= IDLE;
            end else if ((state_q == STREAM) && out_en) begin
                cnt_q <= cnt_d;
            end
        end
    end

    // Operands never exceed FRAME_LEN-1, so the final bit of a frame is always 0.
    assign busy        = (state_q == STREAM);
    assign frame_start = busy && (cnt_q == '0);
    assign a           = busy && (cnt_q < act_a_q);
    assign b           = busy && (cnt_q < act_b_q);
    assign c           = busy && (cnt_q < act_c_q);

endmodule

// File: tb/tb_unary_stream_encoder.sv
// Directed and scoreboard checks for unary_stream_encoder with BIN_BITS=4.
module tb_unary_stream_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_bin, b_bin, c_bin;
    logic       out_en;
    logic       a, b, c;
    logic       frame_start;
    logic       busy;

    int checks = 0;
    int errors = 0;

    unary_stream_encoder #(.BIN_BITS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_bin       (a_bin),
        .b_bin       (b_bin),
        .c_bin       (c_bin),
        .out_en      (out_en),
        .a           (a),
        .b           (b),
        .c           (c),
        .frame_start (frame_start),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [3:0] va, input logic [3:0] vb, input logic [3:0] vc);
        in_valid = 1'b1;
        a_bin    = va;
        b_bin    = vb;
        c_bin    = vc;
    endtask

    // Observes frame positions first..last with out_en held high; drops
    // in_valid once an offered triple has been taken.
    task automatic watch_frame(input logic [3:0] ea, input logic [3:0] eb, input logic [3:0] ec,
                               input int first, input int last, input string tag);
        logic acc;
        for (int i = first; i <= last; i++) begin
            check_eq({tag, "_fs"},   32'(frame_start), 32'(i == 0));
            check_eq({tag, "_busy"}, 32'(busy),        32'd1);
            check_eq({tag, "_a"},    32'(a),           32'(i < int'(ea)));
            check_eq({tag, "_b"},    32'(b),           32'(i < int'(eb)));
            check_eq({tag, "_c"},    32'(c),           32'(i < int'(ec)));
            acc = in_valid && in_ready;
            step();
            if (acc) in_valid = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout got 0 expected 1");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [3:0] qa[$], qb[$], qc[$];
        logic [3:0] ea, eb, ec;
        int  en_cnt, oa, ob, oc, frames_done, sent, budget;
        logic acc, seen;

        reset = 1'b1; in_valid = 1'b0; out_en = 1'b1;
        a_bin = '0; b_bin = '0; c_bin = '0;

        // Reset state
        step(); step();
        check_eq("rst_ready", 32'(in_ready), 32'd0);
        check_eq("rst_busy",  32'(busy),     32'd0);
        check_eq("rst_fs",    32'(frame_start), 32'd0);
        check_eq("rst_abc",   32'({a, b, c}), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rel_ready", 32'(in_ready), 32'd1);

        // Single frame (3,0,15)
        offer(4'd3, 4'd0, 4'd15);
        step();
        in_valid = 1'b0;
        check_eq("f1_wait_busy",  32'(busy),     32'd0);
        check_eq("f1_wait_ready", 32'(in_ready), 32'd0);
        step();
        watch_frame(4'd3, 4'd0, 4'd15, 0, 15, "f1");
        check_eq("f1_idle",  32'(busy),     32'd0);
        check_eq("f1_ready", 32'(in_ready), 32'd1);

        // Back-to-back frames with a third triple held off
        offer(4'd5, 4'd5, 4'd5);
        step();
        offer(4'd1, 4'd2, 4'd3);
        check_eq("bb_full", 32'(in_ready), 32'd0);
        step();
        check_eq("bb_free", 32'(in_ready), 32'd1);
        watch_frame(4'd5, 4'd5, 4'd5, 0, 0, "bb1");
        check_eq("bb_taken", 32'(in_valid), 32'd0);
        check_eq("bb_pend",  32'(in_ready), 32'd0);
        offer(4'd4, 4'd6, 4'd8);
        watch_frame(4'd5, 4'd5, 4'd5, 1, 15, "bb1");
        watch_frame(4'd1, 4'd2, 4'd3, 0, 15, "bb2");
        watch_frame(4'd4, 4'd6, 4'd8, 0, 15, "bb3");
        check_eq("bb_idle",  32'(busy),     32'd0);
        check_eq("bb_ready", 32'(in_ready), 32'd1);

        // Freeze at cnt=2 of (7,7,7)
        offer(4'd7, 4'd7, 4'd7);
        step();
        in_valid = 1'b0;
        step();
        watch_frame(4'd7, 4'd7, 4'd7, 0, 1, "fz");
        out_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("fz_hold_abc",  32'({a, b, c}), 32'd7);
            check_eq("fz_hold_busy", 32'(busy), 32'd1);
            check_eq("fz_hold_fs",   32'(frame_start), 32'd0);
            step();
        end
        out_en = 1'b1;
        watch_frame(4'd7, 4'd7, 4'd7, 2, 15, "fz2");
        check_eq("fz_idle", 32'(busy), 32'd0);

        // Reset at cnt=8 with a pending triple
        offer(4'd9, 4'd9, 4'd9);
        step();
        in_valid = 1'b0;
        step();
        offer(4'd2, 4'd2, 4'd2);
        watch_frame(4'd9, 4'd9, 4'd9, 0, 7, "rs");
        check_eq("rs_pend", 32'(in_ready), 32'd0);
        reset = 1'b1;
        step();
        check_eq("rs_busy",  32'(busy), 32'd0);
        check_eq("rs_abc",   32'({a, b, c}), 32'd0);
        check_eq("rs_fs",    32'(frame_start), 32'd0);
        check_eq("rs_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("rs_rel_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen = seen | busy | a | b | c | frame_start;
            step();
        end
        check_eq("rs_no_residual", 32'(seen), 32'd0);

        // Scoreboard: 100 random triples under random out_en
        en_cnt = 0; oa = 0; ob = 0; oc = 0;
        frames_done = 0; sent = 0; budget = 0;
        while (frames_done < 100 && budget < 20000) begin
            if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0)
                offer(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            out_en = ($urandom_range(0, 2) != 0);
            if (busy && out_en) begin
                if (frame_start) begin
                    en_cnt = 0; oa = 0; ob = 0; oc = 0;
                end
                oa += int'(a); ob += int'(b); oc += int'(c);
                en_cnt++;
                if (en_cnt == 16) begin
                    check_eq("rnd_q", 32'(qa.size() > 0), 32'd1);
                    if (qa.size() > 0) begin
                        ea = qa.pop_front(); eb = qb.pop_front(); ec = qc.pop_front();
                        check_eq("rnd_a", 32'(oa), 32'(ea));
                        check_eq("rnd_b", 32'(ob), 32'(eb));
                        check_eq("rnd_c", 32'(oc), 32'(ec));
                    end
                    frames_done++;
                    en_cnt = 0;
                end
            end
            acc = in_valid && in_ready;
            step();
            if (acc) begin
                qa.push_back(a_bin); qb.push_back(b_bin); qc.push_back(c_bin);
                in_valid = 1'b0;
                sent++;
            end
            budget++;
        end
        check_eq("rnd_frames", 32'(frames_done), 32'd100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
